hdmi_timing_ctrl: RTL and testbench
===================================

HDMI_TIMING_CTRL -- requirements
Module: hdmi_timing_ctrl

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640 visible pixels/line; H_FP 16; H_SYNC 96; H_BP 48; V_ACTIVE 480 visible lines/frame; V_FP 10; V_SYNC 2; V_BP 33; SYNC_POL 0 (0 = sync pulse active-low, 1 = active-high).
REQ-002 SHALL have ports, clock and reset first:
  i_clk  in  1  pixel clock, single clock domain;
  i_rst_n  in  1  asynchronous active-low reset;
  i_enable  in  1  start/continue frame generation;
  i_pixel_rgb  in  24  {R,G,B} pixel, valid the cycle after o_pixel_req;
  o_pixel_req  out  1  pixel request for (o_x,o_y);
  o_x  out  10  active column of request;
  o_y  out  10  active row of request;
  o_frame_start  out  1  one-cycle pulse at first pixel of a frame;
  o_blanking  out  1  to i_blanking of all three TMDS encoders;
  o_ctrl_ch0  out  2  {vsync,hsync} control data for blue channel;
  o_ctrl_ch1  out  2  control data for green channel;
  o_ctrl_ch2  out  2  control data for red channel;
  o_data_ch0  out  8  blue pixel byte;
  o_data_ch1  out  8  green pixel byte;
  o_data_ch2  out  8  red pixel byte.

Function
REQ-003 SHALL hold H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; h counter 0..H_TOTAL-1, v counter 0..V_TOTAL-1, widths sized by $clog2 of totals.
REQ-004 SHALL implement states IDLE and RUN; IDLE -> RUN when i_enable=1, counters (0,0) on first RUN cycle.
REQ-005 In RUN, h SHALL increment each cycle; at H_TOTAL-1 h wraps to 0 and v increments; at (H_TOTAL-1, V_TOTAL-1) both wrap to 0.
REQ-006 Horizontal regions by h: ACTIVE [0,H_ACTIVE), FP, SYNC, BP in that order; vertical regions by v likewise.
REQ-007 i_enable deasserted mid-frame SHALL be ignored until frame end; at (H_TOTAL-1, V_TOTAL-1) with i_enable=0 the block SHALL go to IDLE; i_enable=1 there continues to next frame without gap.
REQ-008 Stage 0 (registered): o_pixel_req=1 iff RUN and h and v both in ACTIVE; o_x=h, o_y=v when requesting, else hold 0; o_frame_start=1 only at (0,0) in RUN.
REQ-009 Upstream SHALL drive i_pixel_rgb in the cycle after o_pixel_req; the block samples it then, no backpressure.
REQ-010 o_blanking, o_ctrl_ch*, o_data_ch* SHALL lag o_pixel_req/o_x/o_y by exactly 2 cycles, so o_data aligns with the sampled i_pixel_rgb.
REQ-011 o_blanking SHALL be 0 exactly for pixels that had o_pixel_req=1, 1 otherwise, including all of IDLE.
REQ-012 hsync SHALL be asserted (level per SYNC_POL) while h in H SYNC region; vsync while v in V SYNC region (whole lines); o_ctrl_ch0={vsync,hsync}; o_ctrl_ch1=o_ctrl_ch2=2'b00.
REQ-013 o_data_ch2/1/0 SHALL be i_pixel_rgb[23:16]/[15:8]/[7:0] when o_blanking=0, 8'h00 when o_blanking=1.
REQ-014 In IDLE, outputs SHALL equal reset values except that pipeline stages drain to those values within 2 cycles.

Reset
REQ-015 i_rst_n=0 SHALL asynchronously force: state IDLE, counters 0, o_pixel_req 0, o_x 0, o_y 0, o_frame_start 0, o_blanking 1, o_data_ch* 0, o_ctrl_ch1/ch2 0, o_ctrl_ch0 = both syncs deasserted (2'b11 if SYNC_POL=0, 2'b00 if 1).
REQ-016 Reset mid-frame SHALL abandon the frame; after release with i_enable=1 the first RUN cycle SHALL be (0,0) with o_frame_start=1.

Verification (small params: H 4/1/2/1, V 3/1/1/1, SYNC_POL 0; H_TOTAL 8, V_TOTAL 6)
REQ-017 Reset release, i_enable=1 -> o_frame_start pulses once every 48 cycles; o_pixel_req high 4 of every 8 cycles on rows 0-2, 12 per frame.
REQ-018 i_pixel_rgb = 24'hAABBCC held -> o_data_ch2/1/0 = AA/BB/CC exactly 2 cycles after each o_pixel_req, 00 whenever o_blanking=1.
REQ-019 Sync check -> o_ctrl_ch0[0]=0 at h=5,6 (after 2-cycle lag), o_ctrl_ch0[1]=0 for all 8 cycles of row v=4; ch1/ch2 always 00.
REQ-020 Drop i_enable at v=1 -> frame completes, IDLE at wrap, o_blanking=1 and no o_pixel_req thereafter; re-enable -> restarts at (0,0).
REQ-021 Assert i_rst_n=0 at v=2,h=3 without clock edge -> outputs at reset values immediately; release -> restart per REQ-016.

Source files
------------

// File: rtl/hdmi_timing_ctrl.sv
// Video raster timing generator feeding three TMDS encoders; pixel request registered, data/ctrl lag it by 2 cycles.
// No backpressure: upstream must supply i_pixel_rgb the cycle after each o_pixel_req.
module hdmi_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int SYNC_POL = 0
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [23:0] i_pixel_rgb,
  output logic        o_pixel_req,
  output logic [9:0]  o_x,
  output logic [9:0]  o_y,
  output logic        o_frame_start,
  output logic        o_blanking,
  output logic [1:0]  o_ctrl_ch0,
  output logic [1:0]  o_ctrl_ch1,
  output logic [1:0]  o_ctrl_ch2,
  output logic [7:0]  o_data_ch0,
  output logic [7:0]  o_data_ch1,
  output logic [7:0]  o_data_ch2
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  localparam logic SYNC_ON  = (SYNC_POL != 0) ? 1'b1 : 1'b0;
  localparam logic SYNC_OFF = ~SYNC_ON;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state;
  logic [HW-1:0] h;
  logic [VW-1:0] v;

  logic run, h_act, v_act, h_sync_on, v_sync_on, pix;

  logic hs0, vs0;
  logic req1, hs1, vs1;

  // Leaving RUN is only possible on the last pixel of a frame, so a frame is never cut short.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
      h     <= '0;
      v     <= '0;
    end else if (state == S_IDLE) begin
      h <= '0;
      v <= '0;
      if (i_enable) state <= S_RUN;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) begin
        v <= '0;
        if (!i_enable) state <= S_IDLE;
      end else begin
        v <= v + 1'b1;
      end
    end else begin
      h <= h + 1'b1;
    end
  end

  assign run       = (state == S_RUN);
  assign h_act     = int'(h) < H_ACTIVE;
  assign v_act     = int'(v) < V_ACTIVE;
  assign h_sync_on = (int'(h) >= H_ACTIVE + H_FP) && (int'(h) < H_ACTIVE + H_FP + H_SYNC);
  assign v_sync_on = (int'(v) >= V_ACTIVE + V_FP) && (int'(v) < V_ACTIVE + V_FP + V_SYNC);
  assign pix       = run && h_act && v_act;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pixel_req   <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      hs0           <= SYNC_OFF;
      vs0           <= SYNC_OFF;
    end else begin
      o_pixel_req   <= pix;
      o_x           <= pix ? 10'(h) : 10'd0;
      o_y           <= pix ? 10'(v) : 10'd0;
      o_frame_start <= run && (h == '0) && (v == '0);
      hs0           <= (run && h_sync_on) ? SYNC_ON : SYNC_OFF;
      vs0           <= (run && v_sync_on) ? SYNC_ON : SYNC_OFF;
    end
  end

  // Middle stage covers the upstream read latency so rgb and its control word leave together.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req1 <= 1'b0;
      hs1  <= SYNC_OFF;
      vs1  <= SYNC_OFF;
    end else begin
      req1 <= o_pixel_req;
      hs1  <= hs0;
      vs1  <= vs0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_blanking <= 1'b1;
      o_ctrl_ch0 <= {SYNC_OFF, SYNC_OFF};
      o_data_ch0 <= '0;
      o_data_ch1 <= '0;
      o_data_ch2 <= '0;
    end else begin
      o_blanking <= ~req1;
      o_ctrl_ch0 <= {vs1, hs1};
      o_data_ch2 <= req1 ? i_pixel_rgb[23:16] : 8'h00;
      o_data_ch1 <= req1 ? i_pixel_rgb[15:8]  : 8'h00;
      o_data_ch0 <= req1 ? i_pixel_rgb[7:0]   : 8'h00;
    end
  end

  assign o_ctrl_ch1 = 2'b00;
  assign o_ctrl_ch2 = 2'b00;

endmodule

// File: tb/tb_hdmi_timing_ctrl.sv
// Bench for hdmi_timing_ctrl with a tiny 8x6 raster; a linear frame-position model predicts every output.
module tb_hdmi_timing_ctrl;
  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam logic [52:0] RST_VEC = {1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b11, 24'h0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0;
  logic [23:0] rgb = 24'h0;
  logic        o_pixel_req, o_frame_start, o_blanking;
  logic [9:0]  o_x, o_y;
  logic [1:0]  o_ctrl_ch0, o_ctrl_ch1, o_ctrl_ch2;
  logic [7:0]  o_data_ch0, o_data_ch1, o_data_ch2;

  hdmi_timing_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_enable(en), .i_pixel_rgb(rgb),
    .o_pixel_req(o_pixel_req), .o_x(o_x), .o_y(o_y), .o_frame_start(o_frame_start),
    .o_blanking(o_blanking), .o_ctrl_ch0(o_ctrl_ch0), .o_ctrl_ch1(o_ctrl_ch1),
    .o_ctrl_ch2(o_ctrl_ch2), .o_data_ch0(o_data_ch0), .o_data_ch1(o_data_ch1),
    .o_data_ch2(o_data_ch2)
  );

  always #5 clk = ~clk;

  // Raster position of one cycle: running flag plus linear index within the frame.
  typedef struct packed {bit run; int k;} pos_t;
  pos_t        cur, c1, c2, c3;
  logic [23:0] rgb1;
  logic [52:0] exp_vec;
  int          vectors = 0, miscompares = 0;

  function automatic logic pix(pos_t p);
    return p.run && ((p.k % HT) < HA) && ((p.k / HT) < VA);
  endfunction

  function automatic logic [52:0] obs();
    return {o_pixel_req, o_x, o_y, o_frame_start, o_blanking, o_ctrl_ch2, o_ctrl_ch1,
            o_ctrl_ch0, o_data_ch2, o_data_ch1, o_data_ch0};
  endfunction

  function automatic logic [52:0] expected();
    int h3, v3;
    logic rq, fs, hs, vs, p3;
    logic [9:0] x, y;
    logic [23:0] d;
    h3 = c3.k % HT;
    v3 = c3.k / HT;
    rq = pix(c1);
    x  = rq ? 10'(c1.k % HT) : 10'd0;
    y  = rq ? 10'(c1.k / HT) : 10'd0;
    fs = c1.run && (c1.k == 0);
    p3 = pix(c3);
    hs = c3.run && (h3 >= HA + HF) && (h3 < HA + HF + HS);
    vs = c3.run && (v3 >= VA + VF) && (v3 < VA + VF + VS);
    d  = p3 ? rgb1 : 24'h0;
    return {rq, x, y, fs, !p3, 2'b00, 2'b00, !vs, !hs, d};
  endfunction

  task automatic model_reset();
    cur = '0; c1 = '0; c2 = '0; c3 = '0; rgb1 = 24'h0;
    exp_vec = expected();
  endtask

  // One clock: advance the model with the inputs that were stable at the edge, then settle.
  task automatic step();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      c3 = c2; c2 = c1; c1 = cur; rgb1 = rgb;
      if (!cur.run) begin
        if (en) begin cur.run = 1'b1; cur.k = 0; end
      end else if (cur.k == FR - 1) begin
        cur.k = 0;
        if (!en) cur.run = 1'b0;
      end else begin
        cur.k++;
      end
    end
    #1;
    exp_vec = expected();
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    en = 1'b1;
    model_reset();
    #1;
    if (obs() !== RST_VEC) begin
      $display("FAIL reset_async got=%h exp=%h", obs(), RST_VEC); miscompares++;
    end
    vectors++;
    for (int i = 0; i < 3; i++) begin
      step();
      if (obs() !== RST_VEC) begin
        $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, obs(), RST_VEC); miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_free_run();
    int fs_cnt = 0, req_cnt = 0;
    rst_n = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 110; i++) begin
      step();
      if (obs() !== exp_vec) begin
        $display("FAIL free_run cyc=%0d got=%h exp=%h", i, obs(), exp_vec); miscompares++;
      end
      vectors++;
      if (i >= 10 && i < 10 + 2 * FR) begin
        fs_cnt  += int'(o_frame_start);
        req_cnt += int'(o_pixel_req);
      end
      rgb = 24'($urandom);
    end
    if (fs_cnt != 2 || req_cnt != 2 * HA * VA) begin
      $display("FAIL free_run_counts frame_start=%0d pixel_req=%0d exp 2 and %0d", fs_cnt, req_cnt, 2 * HA * VA);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_fixed_rgb();
    rgb = 24'hAABBCC;
    for (int i = 0; i < 60; i++) begin
      step();
      if (obs() !== exp_vec) begin
        $display("FAIL fixed_rgb cyc=%0d got=%h exp=%h", i, obs(), exp_vec); miscompares++;
      end
      vectors++;
      if (!o_blanking && {o_data_ch2, o_data_ch1, o_data_ch0} !== 24'hAABBCC) begin
        $display("FAIL fixed_rgb_data cyc=%0d got=%h exp=aabbcc", i, {o_data_ch2, o_data_ch1, o_data_ch0});
        miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_sync();
    int hs_low = 0, vs_low = 0;
    for (int i = 0; i < FR; i++) begin
      rgb = 24'($urandom);
      step();
      if (obs() !== exp_vec) begin
        $display("FAIL sync cyc=%0d got=%h exp=%h", i, obs(), exp_vec); miscompares++;
      end
      vectors++;
      hs_low += int'(!o_ctrl_ch0[0]);
      vs_low += int'(!o_ctrl_ch0[1]);
    end
    if (hs_low != HS * VT || vs_low != VS * HT) begin
      $display("FAIL sync_counts hsync_low=%0d vsync_low=%0d exp %0d and %0d", hs_low, vs_low, HS * VT, VS * HT);
      miscompares++;
    end
    vectors++;
  endtask

  task automatic test_enable_drop();
    int n = 0, late_req = 0;
    while (!(cur.run && cur.k == HT) && n < 100) begin
      step(); n++;
      if (obs() !== exp_vec) begin
        $display("FAIL enable_drop_wait cyc=%0d got=%h exp=%h", n, obs(), exp_vec); miscompares++;
      end
      vectors++;
    end
    if (n >= 100) begin
      $display("FAIL enable_drop_timeout waited=%0d cycles exp <100", n); miscompares++;
    end
    vectors++;
    en = 1'b0;
    for (int i = 0; i < 80; i++) begin
      rgb = 24'($urandom);
      step();
      if (obs() !== exp_vec) begin
        $display("FAIL enable_drop cyc=%0d got=%h exp=%h", i, obs(), exp_vec); miscompares++;
      end
      vectors++;
      if (i >= 60) late_req += int'(o_pixel_req || !o_blanking);
    end
    if (late_req != 0 || cur.run) begin
      $display("FAIL enable_drop_idle active_cycles=%0d exp 0", late_req); miscompares++;
    end
    vectors++;
    en = 1'b1;
    for (int i = 0; i < 60; i++) begin
      rgb = 24'($urandom);
      step();
      if (obs() !== exp_vec) begin
        $display("FAIL re_enable cyc=%0d got=%h exp=%h", i, obs(), exp_vec); miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_random_enable();
    for (int i = 0; i < 300; i++) begin
      en  = 1'($urandom_range(0, 1));
      rgb = 24'($urandom);
      step();
      if (obs() !== exp_vec) begin
        $display("FAIL random_enable cyc=%0d got=%h exp=%h", i, obs(), exp_vec); miscompares++;
      end
      vectors++;
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    en = 1'b1;
    while (!(cur.run && cur.k == 2 * HT + 3) && n < 200) begin
      step(); n++;
      rgb = 24'($urandom);
    end
    if (n >= 200 || o_pixel_req !== 1'b1) begin
      $display("FAIL mid_reset_setup waited=%0d pixel_req=%b exp 1", n, o_pixel_req); miscompares++;
    end
    vectors++;
    #2 rst_n = 1'b0;
    #1 model_reset();
    if (obs() !== RST_VEC) begin
      $display("FAIL mid_reset_async got=%h exp=%h", obs(), RST_VEC); miscompares++;
    end
    vectors++;
    for (int i = 0; i < 2; i++) begin
      step();
      if (obs() !== exp_vec) begin
        $display("FAIL mid_reset_hold cyc=%0d got=%h exp=%h", i, obs(), exp_vec); miscompares++;
      end
      vectors++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step();
      if (obs() !== exp_vec) begin
        $display("FAIL mid_reset_restart cyc=%0d got=%h exp=%h", i, obs(), exp_vec); miscompares++;
      end
      vectors++;
      rgb = 24'($urandom);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_fixed_rgb();
    test_sync();
    test_enable_drop();
    test_random_enable();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
